// File: rtl/segment_capture.sv
// segment_capture: rebuilds per-digit BCD and decimal-point flags from a scanned,
// active-low 7-segment display bus, filtering scan glitches and flagging illegal codes.
module segment_capture #(
    parameter int N_DIGITS   = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_DIGITS-1:0]     digit_sel,
    input  logic [7:0]              segment_code,
    input  logic                    err_clr,
    output logic [4*N_DIGITS-1:0]   bcd_out,
    output logic [N_DIGITS-1:0]     dp_out,
    output logic                    valid,
    output logic                    update,
    output logic                    code_err
);
    localparam int RW = $clog2(STABLE_CNT + 1);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic [1:0] {S_WAIT, S_COUNT, S_HELD} state_t;

    state_t                  r_state, w_next_state;
    logic [N_DIGITS-1:0]     r_sel_s1, r_sel_s2;
    logic [7:0]              r_seg_s1, r_seg_s2;
    logic [RW-1:0]           r_run, w_next_run;
    logic [IW-1:0]           r_idx, w_sel_idx;
    logic [7:0]              r_code;
    logic [4*N_DIGITS-1:0]   r_bcd;
    logic [N_DIGITS-1:0]     r_dp, r_seen, w_low, w_seen_next;
    logic                    r_valid, r_update, r_code_err;
    logic                    w_legal, w_same, w_relatch, w_commit, w_commit_ok, w_changed;
    logic [4:0]              w_dec;

    assign w_low       = ~r_sel_s2;
    assign w_legal     = (w_low != '0) && ((w_low & (w_low - 1'b1)) == '0);
    assign w_same      = w_legal && (w_sel_idx == r_idx) && (r_seg_s2 == r_code);
    assign w_seen_next = r_seen | (N_DIGITS'(1) << r_idx);
    assign w_commit_ok = w_commit && w_dec[4];
    assign w_changed   = (w_dec[3:0] != r_bcd[{r_idx, 2'b00} +: 4]) || (r_dp[r_idx] != ~r_code[7]);

    assign bcd_out  = r_bcd;
    assign dp_out   = r_dp;
    assign valid    = r_valid;
    assign update   = r_update;
    assign code_err = r_code_err;

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (w_low[i]) w_sel_idx = IW'(i);
    end

    always_comb begin
        w_next_state = r_state;
        w_next_run   = r_run;
        w_relatch    = 1'b0;
        w_commit     = 1'b0;
        if (!w_legal) begin
            w_next_state = S_WAIT;
            w_next_run   = '0;
        end else if (r_state == S_WAIT || !w_same) begin
            w_next_state = S_COUNT;
            w_next_run   = RW'(1);
            w_relatch    = 1'b1;
        end else if (r_state == S_COUNT) begin
            w_next_run = r_run + 1'b1;
            if (r_run == RW'(STABLE_CNT - 1)) begin
                w_commit     = 1'b1;
                w_next_state = S_HELD;
            end
        end
    end

    // {legal, value}: a zero top bit marks a pattern that is not a digit or blank
    always_comb begin
        case (r_code[6:0])
            7'h40:   w_dec = 5'h10;
            7'h79:   w_dec = 5'h11;
            7'h24:   w_dec = 5'h12;
            7'h30:   w_dec = 5'h13;
            7'h19:   w_dec = 5'h14;
            7'h12:   w_dec = 5'h15;
            7'h02:   w_dec = 5'h16;
            7'h78:   w_dec = 5'h17;
            7'h00:   w_dec = 5'h18;
            7'h10:   w_dec = 5'h19;
            7'h7F:   w_dec = 5'h1F;
            default: w_dec = 5'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_s1   <= '1;
            r_sel_s2   <= '1;
            r_seg_s1   <= '1;
            r_seg_s2   <= '1;
            r_state    <= S_WAIT;
            r_run      <= '0;
            r_idx      <= '0;
            r_code     <= '0;
            r_bcd      <= '1;
            r_dp       <= '0;
            r_seen     <= '0;
            r_valid    <= 1'b0;
            r_update   <= 1'b0;
            r_code_err <= 1'b0;
        end else begin
            r_sel_s1   <= digit_sel;
            r_sel_s2   <= r_sel_s1;
            r_seg_s1   <= segment_code;
            r_seg_s2   <= r_seg_s1;
            r_state    <= w_next_state;
            r_run      <= w_next_run;
            r_update   <= w_commit_ok && w_changed && (&w_seen_next);
            r_code_err <= (w_commit && !w_dec[4]) || (r_code_err && !err_clr);
            if (w_relatch) begin
                r_idx  <= w_sel_idx;
                r_code <= r_seg_s2;
            end
            if (w_commit_ok) begin
                r_bcd[{r_idx, 2'b00} +: 4] <= w_dec[3:0];
                r_dp[r_idx]                <= ~r_code[7];
                r_seen                     <= w_seen_next;
                r_valid                    <= &w_seen_next;
            end
        end
    end
endmodule

// File: tb/tb_segment_capture.sv
// tb_segment_capture: directed scan vectors; expected output events and spot checks are queued
// by the stimulus and compared by a negedge monitor.
module tb_segment_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  digit_sel = 4'hF;
    logic [7:0]  segment_code = 8'hFF;
    logic        err_clr = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic        valid, update, code_err;

    logic [22:0] exp_q[$];
    logic [22:0] chk_val[$];
    string       chk_name[$];
    logic [22:0] cur, prev, e;
    logic        mon_en = 1'b0, primed = 1'b0, done = 1'b0;
    int          n_vec = 0, n_bad = 0;

    segment_capture #(.N_DIGITS(4), .STABLE_CNT(4)) dut (
        .clk(clk), .rst_n(rst_n), .digit_sel(digit_sel), .segment_code(segment_code),
        .err_clr(err_clr), .bcd_out(bcd_out), .dp_out(dp_out), .valid(valid),
        .update(update), .code_err(code_err)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] t(input logic [15:0] b, input logic [3:0] d,
                                      input logic v, input logic u, input logic er);
        return {b, d, v, u, er};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic [7:0] c, input int n);
        digit_sel = s;
        segment_code = c;
        step(n);
    endtask

    task automatic chk(input string name, input logic [22:0] v);
        chk_name.push_back(name);
        chk_val.push_back(v);
    endtask

    always @(negedge clk) if (mon_en) begin
        cur = {bcd_out, dp_out, valid, update, code_err};
        if (chk_val.size() != 0) begin
            e = chk_val.pop_front();
            n_vec++;
            if (cur !== e) begin
                n_bad++;
                $display("FAIL %s got=%h req=%h", chk_name[0], cur, e);
            end
            chk_name.pop_front();
        end
        if (!primed) begin
            prev = cur;
            primed = 1'b1;
        end else if (cur !== prev) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event got=%h req=no_change", cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    n_bad++;
                    $display("FAIL event got=%h req=%h", cur, e);
                end
            end
            prev = cur;
        end
        if (done) begin
            n_vec++;
            if (exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL missing_events got=%0d req=0", exp_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout req=finish");
        $fatal(1);
    end

    initial begin
        #3 rst_n = 1'b0;
        mon_en = 1'b1;
        chk("reset", t(16'hFFFF, 4'h0, 0, 0, 0));
        step(1);
        rst_n = 1'b1;
        step(2);
        // scan "1234"
        drive(4'b1110, 8'h99, 6); exp_q.push_back(t(16'hFFF4, 4'h0, 0, 0, 0));
        drive(4'b1101, 8'hB0, 6); exp_q.push_back(t(16'hFF34, 4'h0, 0, 0, 0));
        drive(4'b1011, 8'hA4, 6); exp_q.push_back(t(16'hF234, 4'h0, 0, 0, 0));
        drive(4'b0111, 8'hF9, 6);
        exp_q.push_back(t(16'h1234, 4'h0, 1, 1, 0));
        exp_q.push_back(t(16'h1234, 4'h0, 1, 0, 0));
        chk("scan", t(16'h1234, 4'h0, 1, 1, 0));
        // short run broken by a gap, then another short run: never commits
        drive(4'b1011, 8'hF8, 3);
        drive(4'b1111, 8'hFF, 1);
        drive(4'b1011, 8'hF8, 3);
        drive(4'b1111, 8'hFF, 3);
        chk("glitch", t(16'h1234, 4'h0, 1, 0, 0));
        drive(4'b1100, 8'h55, 10);
        chk("twolow", t(16'h1234, 4'h0, 1, 0, 0));
        // blank, blank with dp lit, then 9
        drive(4'b1101, 8'hFF, 6);
        exp_q.push_back(t(16'h12F4, 4'h0, 1, 1, 0));
        exp_q.push_back(t(16'h12F4, 4'h0, 1, 0, 0));
        chk("blank", t(16'h12F4, 4'h0, 1, 1, 0));
        drive(4'b1101, 8'h7F, 6);
        exp_q.push_back(t(16'h12F4, 4'h2, 1, 1, 0));
        exp_q.push_back(t(16'h12F4, 4'h2, 1, 0, 0));
        chk("dp", t(16'h12F4, 4'h2, 1, 1, 0));
        drive(4'b1101, 8'h10, 6);
        exp_q.push_back(t(16'h1294, 4'h2, 1, 1, 0));
        exp_q.push_back(t(16'h1294, 4'h2, 1, 0, 0));
        chk("nine", t(16'h1294, 4'h2, 1, 1, 0));
        // illegal code, clear, then clear racing a new illegal commit
        drive(4'b1110, 8'h55, 6);
        exp_q.push_back(t(16'h1294, 4'h2, 1, 0, 1));
        chk("illegal", t(16'h1294, 4'h2, 1, 0, 1));
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        exp_q.push_back(t(16'h1294, 4'h2, 1, 0, 0));
        chk("clr", t(16'h1294, 4'h2, 1, 0, 0));
        drive(4'b1110, 8'h56, 5);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        exp_q.push_back(t(16'h1294, 4'h2, 1, 0, 1));
        chk("setwins", t(16'h1294, 4'h2, 1, 0, 1));
        drive(4'b1110, 8'h99, 6);
        chk("samecommit", t(16'h1294, 4'h2, 1, 0, 1));
        // async reset mid-run, then first-commit latency
        drive(4'b0111, 8'hF9, 2);
        rst_n = 1'b0;
        digit_sel = 4'hF;
        segment_code = 8'hFF;
        exp_q.push_back(t(16'hFFFF, 4'h0, 0, 0, 0));
        chk("async", t(16'hFFFF, 4'h0, 0, 0, 0));
        step(2);
        rst_n = 1'b1;
        step(2);
        drive(4'b1110, 8'h99, 5);
        chk("early", t(16'hFFFF, 4'h0, 0, 0, 0));
        step(1);
        exp_q.push_back(t(16'hFFF4, 4'h0, 0, 0, 0));
        chk("latency", t(16'hFFF4, 4'h0, 0, 0, 0));
        step(3);
        done = 1'b1;
    end
endmodule
